// File: rtl/pixel_raster_source_pkg.sv
// pixel_raster_source_pkg: shared video widths, FSM encoding and pixel word layout.
`default_nettype none

package pixel_raster_source_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 10;
  localparam int ADDR_W  = 19;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Frame-memory word: R in the top bits, B in the bottom bits.
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

endpackage

`default_nettype wire

// File: rtl/pixel_raster_source_counter.sv
// raster_counter: raster-order x/y scan with a linear word address kept in step.
`default_nettype none

module raster_counter
  import pixel_raster_source_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last_pixel
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // Address tracks y*H_ACTIVE+x by plain increment, so no multiplier is needed.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (x == X_LAST) begin
        x    <= '0;
        y    <= y + COORD_W'(1);
        addr <= addr + ADDR_W'(1);
      end else begin
        x    <= x + COORD_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_raster_source.sv
// pixel_raster_source: reads a frame from memory in raster order and presents
// it as a valid/ready pixel stream with frame start/done markers.
`default_nettype none

module pixel_raster_source
  import pixel_raster_source_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CONTINUOUS = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [3*COLOR_W-1:0]   mem_data,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic [COLOR_W-1:0]     out_R,
  output logic [COLOR_W-1:0]     out_G,
  output logic [COLOR_W-1:0]     out_B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   busy
);

  state_t               state;
  logic                 stop_pending;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic [ADDR_W-1:0]    addr;
  logic                 last_pixel;
  logic                 accept;
  logic                 clear;
  logic                 advance;
  pixel_t               px;

  assign accept   = (state == ST_PRESENT) && out_ready;
  assign clear    = ((state == ST_IDLE) && start) || (accept && last_pixel);
  assign advance  = accept && !last_pixel;
  assign px       = pixel_t'(mem_data);
  assign mem_addr = addr;
  assign busy     = (state != ST_IDLE);

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .advance    (advance),
    .x          (x),
    .y          (y),
    .addr       (addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      stop_pending <= 1'b0;
      mem_rd       <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      out_R        <= '0;
      out_G        <= '0;
      out_B        <= '0;
      out_valid    <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      frame_done <= 1'b0;
      if (stop && (state != ST_IDLE)) stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        // Entered from IDLE with mem_rd low (one setup cycle), or from an
        // accept with mem_rd already raised; either way it is high one cycle.
        ST_FETCH: begin
          if (!mem_rd) begin
            mem_rd <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          out_x       <= x;
          out_y       <= y;
          out_R       <= px.r;
          out_G       <= px.g;
          out_B       <= px.b;
          out_valid   <= 1'b1;
          frame_start <= (x == '0) && (y == '0);
          state       <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (last_pixel) begin
              frame_done <= 1'b1;
              if ((CONTINUOUS != 0) && !stop_pending && !stop) begin
                state  <= ST_FETCH;
                mem_rd <= 1'b1;
              end else begin
                state        <= ST_IDLE;
                stop_pending <= 1'b0;
              end
            end else begin
              state  <= ST_FETCH;
              mem_rd <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_raster_source.sv
// tb_pixel_raster_source: scoreboard bench for a 4x3 raster, one DUT per
// CONTINUOUS setting sharing the same stimulus.
`default_nettype none

module tb_pixel_raster_source;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset     = 1'b1;
  logic start     = 1'b0;
  logic stop      = 1'b0;
  logic out_ready = 1'b1;
  int   sel = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic        mem_rd      [2];
  logic [18:0] mem_addr    [2];
  logic [10:0] out_x       [2];
  logic [10:0] out_y       [2];
  logic [9:0]  out_R       [2];
  logic [9:0]  out_G       [2];
  logic [9:0]  out_B       [2];
  logic        out_valid   [2];
  logic        frame_start [2];
  logic        frame_done  [2];
  logic        busy        [2];

  function automatic logic [29:0] mem_word(input logic [18:0] a);
    logic [9:0] r, g, b;
    r = 10'(a * 7 + 5);
    g = 10'(a * 3 + 1);
    b = 10'(a);
    return {r, g, b};
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [29:0] md;
      // Memory returns data the cycle after the read strobe, garbage otherwise.
      always @(posedge clock) md <= mem_rd[g] ? mem_word(mem_addr[g]) : '1;
      pixel_raster_source #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .CONTINUOUS (g)
      ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mem_rd      (mem_rd[g]),
        .mem_addr    (mem_addr[g]),
        .mem_data    (md),
        .out_x       (out_x[g]),
        .out_y       (out_y[g]),
        .out_R       (out_R[g]),
        .out_G       (out_G[g]),
        .out_B       (out_B[g]),
        .out_valid   (out_valid[g]),
        .out_ready   (out_ready),
        .frame_start (frame_start[g]),
        .frame_done  (frame_done[g]),
        .busy        (busy[g])
      );
    end
  endgenerate

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [29:0] d;
    logic        fs;
  } pix_t;

  pix_t exp_q[$];

  function automatic void push_pixels(input int first, input int count);
    pix_t p;
    for (int i = 0; i < count; i++) begin
      int idx;
      idx  = (first + i) % NPIX;
      p.x  = 11'(idx % H);
      p.y  = 11'(idx / H);
      p.d  = mem_word(19'(idx));
      p.fs = (idx == 0);
      exp_q.push_back(p);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Drives the frame, pops the scoreboard on every accepted pixel.
  task automatic score_frame(input bit do_start, input bit hold_start, input bit with_stop,
                             input bit need_idle, input int stall_idx, input int stop_idx,
                             input int budget, output int n_edge, output int first_rd,
                             output int first_val, output int reads, output int dones,
                             output int bad_gaps);
    int   pix = 0, stall_left = 5, last_acc = -1;
    bit   fresh = 1'b1, fin = 1'b0;
    pix_t e;
    reads = 0; dones = 0; bad_gaps = 0; first_rd = -1; first_val = -1; n_edge = -1;
    if (do_start) begin
      @(negedge clock);
      start = 1'b1; stop = with_stop; n_edge = cyc + 1;
    end
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clock);
      start = hold_start; stop = 1'b0; out_ready = 1'b1;
      if (mem_rd[sel]) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (frame_done[sel]) dones++;
      if (out_valid[sel]) begin
        if (first_val < 0) first_val = cyc;
        if (fresh && last_acc >= 0 && (cyc - last_acc) != 3) bad_gaps++;
        fresh = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: got (%0d,%0d), required no pixel", out_x[sel], out_y[sel]);
        end else begin
          e = exp_q[0];
          if ({out_x[sel], out_y[sel], out_R[sel], out_G[sel], out_B[sel], frame_start[sel]}
              !== {e.x, e.y, e.d, e.fs}) begin
            n_fail++;
            $display("FAIL pixel: got (%0d,%0d) rgb=%h fs=%b, required (%0d,%0d) rgb=%h fs=%b",
                     out_x[sel], out_y[sel], {out_R[sel], out_G[sel], out_B[sel]},
                     frame_start[sel], e.x, e.y, e.d, e.fs);
          end
          if (pix == stall_idx && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            void'(exp_q.pop_front());
            last_acc = cyc;
            fresh    = 1'b1;
            if (pix == stop_idx) stop = 1'b1;
            pix++;
          end
        end
      end
      if (exp_q.size() == 0 && (!need_idle || !busy[sel])) fin = 1'b1;
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: got %0d pixels left, required 0 within %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic count_idle_reads(input int cycles, output int rds, output int dn);
    rds = 0; dn = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (mem_rd[sel]) rds++;
      if (frame_done[sel] || busy[sel]) dn++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({mem_rd[g], mem_addr[g], out_x[g], out_y[g], out_R[g], out_G[g], out_B[g],
           out_valid[g], frame_start[g], frame_done[g], busy[g]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got busy=%b valid=%b rd=%b addr=%0d, required all 0",
                 g, busy[g], out_valid[g], mem_rd[g], mem_addr[g]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int n, frd, fv, rds, dn, gaps, irds, idn;
    sel = 0; do_reset(); push_pixels(0, NPIX);
    score_frame(1, 0, 0, 1, -1, -1, 200, n, frd, fv, rds, dn, gaps);
    n_checks++; if (frd !== n + 1) begin n_fail++; $display("FAIL latency_rd: got %0d, required %0d", frd, n + 1); end
    n_checks++; if (fv !== n + 3) begin n_fail++; $display("FAIL latency_valid: got %0d, required %0d", fv, n + 3); end
    n_checks++; if (rds !== NPIX) begin n_fail++; $display("FAIL single_reads: got %0d, required %0d", rds, NPIX); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL single_done: got %0d, required 1", dn); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL pixel_spacing: got %0d bad gaps, required 0", gaps); end
    count_idle_reads(10, irds, idn);
    n_checks++; if (irds + idn !== 0) begin n_fail++; $display("FAIL single_idle: got %0d reads %0d busy/done, required 0", irds, idn); end
  endtask

  task automatic test_backpressure();
    int n, frd, fv, rds, dn, gaps;
    sel = 0; do_reset(); push_pixels(0, NPIX);
    score_frame(1, 0, 0, 1, 6, -1, 200, n, frd, fv, rds, dn, gaps);
    n_checks++; if (rds !== NPIX) begin n_fail++; $display("FAIL stall_reads: got %0d, required %0d", rds, NPIX); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL stall_done: got %0d, required 1", dn); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL stall_spacing: got %0d bad gaps, required 0", gaps); end
  endtask

  task automatic test_stop_continuous();
    int n, frd, fv, rds, dn, gaps, irds, idn;
    sel = 1; do_reset(); push_pixels(0, NPIX);
    score_frame(1, 0, 0, 1, -1, 5, 200, n, frd, fv, rds, dn, gaps);
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL stop_done: got %0d, required 1", dn); end
    n_checks++; if (rds !== NPIX) begin n_fail++; $display("FAIL stop_reads: got %0d, required %0d", rds, NPIX); end
    count_idle_reads(10, irds, idn);
    n_checks++; if (irds + idn !== 0) begin n_fail++; $display("FAIL stop_idle: got %0d reads %0d busy/done, required 0", irds, idn); end
  endtask

  task automatic test_continuous_wrap();
    int n, frd, fv, rds, dn, gaps;
    sel = 1; do_reset();
    // A lone stop in IDLE must be ignored, then start+stop together: start wins.
    @(negedge clock); stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL idle_stop: got busy=%b, required 0", busy[1]); end
    push_pixels(0, NPIX + 4);
    score_frame(1, 0, 1, 0, -1, -1, 300, n, frd, fv, rds, dn, gaps);
    n_checks++; if (rds !== NPIX + 4) begin n_fail++; $display("FAIL wrap_reads: got %0d, required %0d", rds, NPIX + 4); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d, required 1", dn); end
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_busy: got %b, required 1", busy[1]); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL wrap_spacing: got %0d bad gaps, required 0", gaps); end
  endtask

  task automatic test_reset_midframe();
    int n, frd, fv, rds, dn, gaps;
    bit hit = 1'b0;
    sel = 0; do_reset();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      if (out_valid[0] && out_x[0] == 11'd3 && out_y[0] == 11'd0) hit = 1'b1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL reach_3_0: got no pixel (3,0), required one"); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({mem_rd[0], mem_addr[0], out_x[0], out_y[0], out_R[0], out_G[0], out_B[0],
         out_valid[0], frame_start[0], frame_done[0], busy[0]} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got busy=%b valid=%b done=%b x=%0d, required all 0",
               busy[0], out_valid[0], frame_done[0], out_x[0]);
    end
    reset = 1'b0;
    push_pixels(0, NPIX);
    score_frame(1, 0, 0, 1, -1, -1, 200, n, frd, fv, rds, dn, gaps);
    n_checks++; if (fv !== n + 3) begin n_fail++; $display("FAIL restart_latency: got %0d, required %0d", fv, n + 3); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL restart_done: got %0d, required 1", dn); end
  endtask

  task automatic test_start_held();
    int n, frd, fv, rds, dn, gaps;
    sel = 0; do_reset();
    for (int f = 0; f < 2; f++) begin
      push_pixels(0, NPIX);
      score_frame(f == 0, 1, 0, 1, -1, -1, 200, n, frd, fv, rds, dn, gaps);
      n_checks++; if (rds !== NPIX) begin n_fail++; $display("FAIL held_reads[%0d]: got %0d, required %0d", f, rds, NPIX); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL held_done[%0d]: got %0d, required 1", f, dn); end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_stop_continuous();
    test_continuous_wrap();
    test_reset_midframe();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/pixel_raster_source.md
PIXEL_RASTER_SOURCE -- requirements
Module: pixel_raster_source

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-003 SHALL have parameter CONTINUOUS, default 1; 1 = restart the next frame automatically, 0 = one frame per start.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a frame when idle.
REQ-007 SHALL have port stop  in  1  finish the current frame, then go idle.
REQ-008 SHALL have port mem_rd  out  1  frame-memory read strobe.
REQ-009 SHALL have port mem_addr  out  19  frame-memory word address.
REQ-010 SHALL have port mem_data  in  30  read data {R[29:20],G[19:10],B[9:0]}, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have ports out_x / out_y  out  11  pixel coordinates.
REQ-012 SHALL have ports out_R / out_G / out_B  out  10  pixel colour.
REQ-013 SHALL have port out_valid  out  1  pixel presented.
REQ-014 SHALL have port out_ready  in  1  consumer accepts the pixel.
REQ-015 SHALL have port frame_start  out  1  high with out_valid for pixel (0,0).
REQ-016 SHALL have port frame_done  out  1  1-cycle pulse after the last pixel is accepted.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM IDLE, FETCH, WAIT, PRESENT.
REQ-019 IDLE->FETCH when start=1 is sampled; x, y and address are cleared to 0.
REQ-020 FETCH: mem_rd=1 for exactly one cycle, mem_addr=y*H_ACTIVE+x (incremental counter, no multiplier); then ->WAIT.
REQ-021 WAIT: mem_data and the current x/y are latched into the output registers; then ->PRESENT.
REQ-022 PRESENT: out_valid=1; all out_* SHALL hold stable until out_valid&&out_ready; on accept, advance and ->FETCH, or end the frame.
REQ-023 Latency: start sampled at edge N -> mem_rd high after edge N+1 -> out_valid high after edge N+3; with out_ready tied high, one pixel per 3 cycles.
REQ-024 Advance: x wraps from H_ACTIVE-1 to 0 with y+1; address increments by 1.
REQ-025 Frame end: accept at x=H_ACTIVE-1, y=V_ACTIVE-1 SHALL pulse frame_done the next cycle.
REQ-026 At frame end, if CONTINUOUS=1 and no stop is pending: clear x, y and address, then ->FETCH; otherwise ->IDLE.
REQ-027 A stop pulse at any time while busy SHALL set stop_pending; it is cleared on entering IDLE.
REQ-028 A stop sampled in IDLE SHALL be ignored.
REQ-029 start while busy SHALL be ignored.
REQ-030 If start and stop are sampled together in IDLE, start wins and stop is ignored.
REQ-031 frame_start = out_valid && x==0 && y==0.
REQ-032 out_valid SHALL never deassert without acceptance, except on reset.

Reset
REQ-033 reset SHALL force state IDLE and set stop_pending=0.
REQ-034 reset SHALL set all outputs to 0: out_x, out_y, out_R/G/B, out_valid, mem_rd, mem_addr, frame_start, frame_done, busy.
REQ-035 reset asserted mid-frame SHALL abandon the frame; frame_done is not pulsed.

Structure
REQ-036 SHALL place the FSM state encoding, coordinate width (11), colour width (10) and address width (19) in a shared video package.
REQ-037 SHALL place the x/y/address scan counter in one sub-module, raster_counter (inputs clear and advance; outputs x, y, addr, last_pixel).

Verification (H_ACTIVE=4, V_ACTIVE=3)
REQ-038 Single frame, CONTINUOUS=0, out_ready=1, mem_data=addr -> 12 pixels (0,0)..(3,2), B=0..11, frame_done 1 pulse, then IDLE.
REQ-039 Latency: start at cycle 0 -> mem_rd at cycle 1, out_valid at cycle 3, pixel spacing 3 cycles.
REQ-040 Backpressure: out_ready low for 5 cycles on pixel (2,1) -> outputs held stable, no extra mem_rd, sequence intact.
REQ-041 CONTINUOUS=1, stop pulsed at pixel (1,1) -> frame completes, frame_done pulses, IDLE, no second mem_rd.
REQ-042 reset at pixel (3,0) -> next cycle all outputs 0 and IDLE; a fresh start begins again at (0,0), addr 0.
REQ-043 start held high for the whole frame with CONTINUOUS=0 -> exactly one frame per return to IDLE; frame_start only on (0,0).
